// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, byte-mask constants and the request struct latched at acceptance.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_BUSY = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_st_e;

  // Unshifted lane masks for byte/half/word/double accesses.
  localparam logic [7:0] MEM_MASK_B = 8'h01;
  localparam logic [7:0] MEM_MASK_H = 8'h03;
  localparam logic [7:0] MEM_MASK_W = 8'h0F;
  localparam logic [7:0] MEM_MASK_D = 8'hFF;

  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } dmem_req_t;

  function automatic logic [63:0] lane_bits(input logic [7:0] mask);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{mask[i]}};
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port 2^ADDR_W x 64 storage with per-byte write enables and a registered read.
// Reads return only the masked lanes; a write cycle returns zero.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [63:0]       wdata,
  input  logic [7:0]        mask,
  output logic [63:0]       rdata
);

  logic [63:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) rdata <= we ? '0 : (mem[idx] & lane_bits(mask));
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, byte-masked
// stores and loads, out-of-range error, valid/ready response held until consumed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  dmem_st_e    state, state_nxt;
  logic [3:0]  cnt;
  dmem_req_t   req_q;
  logic        err_q;
  logic        acc_fire, access, rsp_fire, in_range;
  logic [63:0] woff, arr_rdata;

  // Word offset from BASE; an address below BASE wraps and is caught by the compare.
  assign woff     = (req_q.addr - BASE) >> 3;
  assign in_range = (req_q.addr >= BASE) && (woff[63:ADDR_W] == '0);
  assign acc_fire = req_valid && req_ready;
  assign access   = (state == DMEM_ST_BUSY) && (cnt == 4'd0);
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DMEM_ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_ST_IDLE: if (acc_fire)   state_nxt = DMEM_ST_BUSY;
      DMEM_ST_BUSY: if (cnt == '0)  state_nxt = DMEM_ST_RESP;
      DMEM_ST_RESP: if (rsp_ready)  state_nxt = DMEM_ST_IDLE;
      default:                      state_nxt = DMEM_ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      DMEM_ST_IDLE: req_ready = rst_n;
      DMEM_ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (acc_fire) begin
        req_q <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, mask: req_mask};
        cnt   <= 4'(LATENCY - 1);
      end else if (state == DMEM_ST_BUSY && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (access)        err_q <= !in_range;
      else if (rsp_fire) err_q <= 1'b0;
    end
  end

  // Out-of-range accesses never enable the array, so no write can land.
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (access && in_range),
    .we    (req_q.wen),
    .idx   (woff[ADDR_W-1:0]),
    .wdata (req_q.wdata),
    .mask  (req_q.mask),
    .rdata (arr_rdata)
  );

  assign rsp_rdata = (state == DMEM_ST_RESP && !err_q) ? arr_rdata : '0;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked
// against a byte-addressed reference memory; a monitor per instance pops and compares.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          NI        = 3;
  localparam int          LATS [NI] = '{2, 1, 15};
  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam logic [63:0] SPAN      = 64'd8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [NI-1:0][63:0] req_addr, req_wdata, rsp_rdata;
  logic [NI-1:0][7:0]  req_mask;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       exp_q [NI][$];
  logic [7:0] mdl [longint];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    dmem_responder #(.ADDR_W(10), .LATENCY(LATS[k]), .BASE(BASE)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[k]),
      .req_ready (req_ready[k]),
      .req_wen   (req_wen[k]),
      .req_addr  (req_addr[k]),
      .req_wdata (req_wdata[k]),
      .req_mask  (req_mask[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k]),
      .rsp_rdata (rsp_rdata[k]),
      .rsp_err   (rsp_err[k])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic longint key(input int k, input logic [63:0] a);
    return (longint'(k) << 60) | longint'(a[59:0]);
  endfunction

  function automatic bit inr(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic logic [63:0] mget(input int k, input logic [63:0] a);
    logic [63:0] w;
    logic [63:0] b;
    w = '0;
    b = {a[63:3], 3'b000};
    for (int i = 0; i < 8; i++)
      if (mdl.exists(key(k, b + 64'(i)))) w[8*i +: 8] = mdl[key(k, b + 64'(i))];
    return w;
  endfunction

  task automatic mput(input int k, input logic [63:0] a, input logic [63:0] w);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    for (int i = 0; i < 8; i++) mdl[key(k, b + 64'(i))] = w[8*i +: 8];
  endtask

  // Monitors: latency at rsp_valid rise, data/err at each handshake.
  for (genvar k = 0; k < NI; k++) begin : g_mon
    logic prev;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        prev <= 1'b0;
      end else begin
        if (rsp_valid[k] && !prev && exp_q[k].size() > 0)
          chk($sformatf("latency_i%0d", k), 64'(cyc - exp_q[k][0].acc), 64'(LATS[k]));
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_rsp_i%0d", k), 64'd1, 64'd0);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("rdata_i%0d", k), rsp_rdata[k], e.rdata);
            chk($sformatf("err_i%0d", k), 64'(rsp_err[k]), 64'(e.err));
          end
        end
        prev <= rsp_valid[k];
      end
    end
  end

  task automatic issue(input int k, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] m, output int acc);
    exp_t        e;
    logic [63:0] w;
    int          t;
    e.rdata = '0;
    e.err   = !inr(addr);
    if (!e.err) begin
      w = mget(k, addr);
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          if (wen) w[8*i +: 8] = wd[8*i +: 8];
          else     e.rdata[8*i +: 8] = w[8*i +: 8];
        end
      end
      if (wen) mput(k, addr, w);
    end
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_mask[k]  = m;
    t = 0;
    while (!req_ready[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      chk("accept_timeout", 64'd0, 64'd1);
      acc = -1;
      req_valid[k] = 1'b0;
      return;
    end
    acc   = cyc + 1;
    e.acc = acc;
    exp_q[k].push_back(e);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (exp_q[k].size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_rsp(input int k);
    int t;
    t = 0;
    while (!rsp_valid[k] && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("rsp_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic op(input int k, input logic wen, input logic [63:0] addr,
                    input logic [63:0] wd, input logic [7:0] m);
    int acc;
    issue(k, wen, addr, wd, m, acc);
    wait_done(k);
  endtask

  task automatic rand_run(input int k);
    logic [63:0] wa [4];
    logic [63:0] a, wd;
    logic [7:0]  m;
    for (int i = 0; i < 4; i++) begin
      wa[i] = BASE + 64'(8 * $urandom_range(0, 1023));
      op(k, 1'b1, wa[i], {$urandom, $urandom}, MEM_MASK_D);
    end
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0:       m = MEM_MASK_B << $urandom_range(0, 7);
        1:       m = MEM_MASK_H << (2 * $urandom_range(0, 3));
        2:       m = MEM_MASK_W << (4 * $urandom_range(0, 1));
        3:       m = MEM_MASK_D;
        default: m = 8'h00;
      endcase
      a = wa[$urandom_range(0, 3)] | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) != 0) ? (BASE - 64'd8) : (BASE + SPAN + 64'(8 * $urandom_range(0, 7)));
      wd = {$urandom, $urandom};
      op(k, 1'($urandom_range(0, 1)), a, wd, m);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, h;
    logic [63:0] old;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    rsp_ready = '1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 64'd0);
    chk("rst_rsp_err",   64'(rsp_err[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 64'(req_ready[0]), 64'd1);

    // Basic store / load and masked merge
    op(0, 1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF);
    op(0, 1'b0, 64'h8000_0008, 64'h0, 8'hFF);
    op(0, 1'b1, 64'h8000_0008, 64'hAAAA_0000_0000_0000, 8'hC0);
    op(0, 1'b0, 64'h8000_0008, 64'h0, 8'hFF);
    op(0, 1'b0, 64'h8000_0008, 64'h0, 8'h0F);
    op(0, 1'b0, 64'h8000_000D, 64'h0, 8'h00);
    op(0, 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);

    // Range boundaries
    op(0, 1'b1, BASE, 64'h0123_4567_89AB_CDEF, 8'hFF);
    op(0, 1'b1, BASE + 64'd8 * 1023, 64'hFEDC_BA98_7654_3210, 8'hFF);
    op(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'hFF);
    op(0, 1'b0, 64'h8000_2000, 64'h0, 8'hFF);
    op(0, 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    op(0, 1'b0, BASE, 64'h0, 8'hFF);
    op(0, 1'b0, BASE + 64'd8 * 1023, 64'h0, 8'hFF);

    // Back-pressure in RESP
    @(posedge clk); #1 rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 64'h8000_0008, 64'h0, 8'hFF, acc);
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid[0] = ~req_valid[0];
      req_wen[0]   = 1'b1;
      req_addr[0]  = BASE + 64'd16;
      req_mask[0]  = 8'hFF;
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("hold_rsp_rdata", rsp_rdata[0], 64'hAAAA334455667788);
      chk("hold_rsp_err",   64'(rsp_err[0]), 64'd0);
      chk("hold_req_ready", 64'(req_ready[0]), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    h = cyc + 1;
    issue(0, 1'b0, BASE, 64'h0, 8'hFF, acc);
    chk("pending_accept_edge", 64'(acc), 64'(h + 1));
    wait_done(0);

    // Reset during BUSY drops the store
    op(0, 1'b1, BASE + 64'd16, 64'h0, 8'hFF);
    old = mget(0, BASE + 64'd16);
    issue(0, 1'b1, BASE + 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q[0].delete();
    mput(0, BASE + 64'd16, old);
    #1 chk("rst_busy_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 1'b0, BASE + 64'd16, 64'h0, 8'hFF);

    // Reset during RESP keeps the committed store
    @(posedge clk); #1 rsp_ready[0] = 1'b0;
    issue(0, 1'b1, BASE + 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc);
    wait_rsp(0);
    rst_n = 1'b0;
    exp_q[0].delete();
    rsp_ready[0] = 1'b1;
    #1 chk("rst_resp_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 1'b0, BASE + 64'd16, 64'h0, 8'hFF);

    // Randomized traffic on every latency
    for (int k = 0; k < NI; k++) rand_run(k);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
